lhs_csr_packer: RTL and testbench

LHS_CSR_PACKER -- requirements
Module: lhs_csr_packer

---
 rtl/spmm_pkg.sv | 21 ++
 rtl/lhs_csr_packer_entry_buf.sv | 43 ++++
 rtl/lhs_csr_packer.sv | 150 +++++++++++++++
 tb/tb_lhs_csr_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spmm_pkg.sv
// Shared definitions for the SpMM datapath and its LHS CSR packer.
//   N     : matrix dimension and number of lanes per beat
//   W     : data width
//   lgN   : row/column index width
//   dbLgN : pointer / buffer address width (indexes N*N entries)
package spmm_pkg;

    localparam int N     = 16;
    localparam int W     = 8;
    localparam int lgN   = $clog2(N);
    localparam int dbLgN = 2 * $clog2(N);

    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } packer_state_t;

endpackage

// File: rtl/lhs_csr_packer_entry_buf.sv
// lhs_entry_buf: N*N-entry store of {col, data} written in arrival order.
// Ports:
//   clock              rising-edge clock
//   wr_en              write strobe
//   wr_addr            entry slot to write
//   wr_col, wr_data    entry contents
//   rd_beat            beat index; lane j reads slot rd_beat*N + j
//   rd_col, rd_data    N-lane read data, lane j at [j*width +: width]
// The array has no reset: lanes beyond the valid count are masked by the
// packer, so stale contents are never visible.
module lhs_entry_buf
    import spmm_pkg::*;
(
    input  logic               clock,
    input  logic               wr_en,
    input  logic [dbLgN-1:0]   wr_addr,
    input  logic [lgN-1:0]     wr_col,
    input  logic [W-1:0]       wr_data,
    input  logic [lgN-1:0]     rd_beat,
    output logic [N*lgN-1:0]   rd_col,
    output logic [N*W-1:0]     rd_data
);

    logic [lgN-1:0] col_mem  [N*N];
    data_t          data_mem [N*N];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            col_mem[wr_addr]  <= wr_col;
            data_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_col  = '0;
        rd_data = '0;
        for (int j = 0; j < N; j++) begin
            rd_col[j*lgN +: lgN] = col_mem[{rd_beat, lgN'(j)}];
            rd_data[j*W +: W]    = data_mem[{rd_beat, lgN'(j)}];
        end
    end

endmodule

// File: rtl/lhs_csr_packer.sv
// lhs_csr_packer: collects row-ordered nonzero entries of one matrix and
// emits them as CSR beats (row pointers + N lanes of col/data) to the SpMM.
// Ports:
//   clock, reset                 clock, async active-high reset
//   in_valid/in_ready            entry handshake
//   in_row, in_col, in_data      entry coordinates and value
//   in_last                      entry closes the matrix
//   lhs_ready_ns                 downstream accepts a beat
//   lhs_valid/start/last         beat present / first beat / final beat
//   lhs_ptr                      N row-start pointers, row r at [r*dbLgN +: dbLgN]
//   lhs_col, lhs_data            N lanes of column index / value
//   busy                         not idle
//   err                          sticky protocol error (row order or overflow)
//
// state      | meaning
// ST_IDLE    | waiting for the first entry of a matrix
// ST_COLLECT | storing entries until in_last
// ST_EMIT    | presenting beats until the lhs_last handshake
module lhs_csr_packer
    import spmm_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [lgN-1:0]       in_row,
    input  logic [lgN-1:0]       in_col,
    input  logic [W-1:0]         in_data,
    input  logic                 in_last,
    input  logic                 lhs_ready_ns,
    output logic                 lhs_valid,
    output logic                 lhs_start,
    output logic                 lhs_last,
    output logic [N*dbLgN-1:0]   lhs_ptr,
    output logic [N*lgN-1:0]     lhs_col,
    output logic [N*W-1:0]       lhs_data,
    output logic                 busy,
    output logic                 err
);

    localparam logic [dbLgN:0] NNZ_FULL = (dbLgN+1)'(N * N);
    localparam logic [dbLgN:0] BEAT_SZ  = (dbLgN+1)'(N);

    packer_state_t        state, state_nxt;
    logic [dbLgN:0]       nnz;
    logic [lgN-1:0]       last_row;
    logic [lgN-1:0]       beat;
    logic [N*dbLgN-1:0]   ptr_q;
    logic [N*lgN-1:0]     buf_col;
    logic [N*W-1:0]       buf_data;
    logic                 accept, drop, store, beat_xfer;
    logic [dbLgN:0]       beat_base;

    assign accept    = in_valid && in_ready;
    assign drop      = (nnz == NNZ_FULL) || (in_row < last_row);
    assign store     = accept && !drop;
    assign beat_xfer = lhs_valid && lhs_ready_ns;
    assign beat_base = {1'b0, beat, lgN'(0)};

    // Final beat once this beat's window reaches nnz; nnz==0 still yields
    // one (empty) beat.
    assign lhs_start = lhs_valid && (beat == '0);
    assign lhs_last  = lhs_valid && ((beat_base + BEAT_SZ) >= nnz);
    assign lhs_ptr   = ptr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        lhs_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = in_last ? ST_EMIT : ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                lhs_valid = 1'b1;
                if (lhs_ready_ns && lhs_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Rows arrive non-decreasing, so a stored entry in row r bumps every
    // pointer above r; pointers are complete the moment in_last is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nnz      <= '0;
            last_row <= '0;
            beat     <= '0;
            ptr_q    <= '0;
            err      <= 1'b0;
        end else begin
            if (accept && state == ST_IDLE) err <= 1'b0;
            if (accept && drop)             err <= 1'b1;
            if (store) begin
                nnz      <= nnz + 1'b1;
                last_row <= in_row;
                for (int k = 0; k < N; k++) begin
                    if (lgN'(k) > in_row)
                        ptr_q[k*dbLgN +: dbLgN] <= ptr_q[k*dbLgN +: dbLgN] + dbLgN'(1);
                end
            end
            if (beat_xfer) begin
                if (lhs_last) begin
                    beat     <= '0;
                    nnz      <= '0;
                    last_row <= '0;
                    ptr_q    <= '0;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    lhs_entry_buf u_buf (
        .clock   (clock),
        .wr_en   (store),
        .wr_addr (nnz[dbLgN-1:0]),
        .wr_col  (in_col),
        .wr_data (in_data),
        .rd_beat (beat),
        .rd_col  (buf_col),
        .rd_data (buf_data)
    );

    // Gating on lhs_valid also zeroes the lanes asynchronously on reset.
    always_comb begin
        lhs_col  = '0;
        lhs_data = '0;
        for (int j = 0; j < N; j++) begin
            if (lhs_valid && ((beat_base + (dbLgN+1)'(j)) < nnz)) begin
                lhs_col[j*lgN +: lgN] = buf_col[j*lgN +: lgN];
                lhs_data[j*W +: W]    = buf_data[j*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_lhs_csr_packer.sv
module tb_lhs_csr_packer;
    import spmm_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 in_valid, in_ready, in_last;
    logic [lgN-1:0]       in_row, in_col;
    logic [W-1:0]         in_data;
    logic                 lhs_ready_ns, lhs_valid, lhs_start, lhs_last, busy, err;
    logic [N*dbLgN-1:0]   lhs_ptr;
    logic [N*lgN-1:0]     lhs_col;
    logic [N*W-1:0]       lhs_data;

    lhs_csr_packer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_data(in_data), .in_last(in_last),
        .lhs_ready_ns(lhs_ready_ns), .lhs_valid(lhs_valid),
        .lhs_start(lhs_start), .lhs_last(lhs_last),
        .lhs_ptr(lhs_ptr), .lhs_col(lhs_col), .lhs_data(lhs_data),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic               s;
        logic               l;
        logic [N*dbLgN-1:0] ptr;
        logic [N*lgN-1:0]   col;
        logic [N*W-1:0]     data;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    mrow[$], mcol[$], mdata[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic add(input int r, input int c, input int d);
        mrow.push_back(r);
        mcol.push_back(c);
        mdata.push_back(d);
    endtask

    // Scoreboard monitor: compares the head beat every valid cycle (so a
    // stalled beat is checked for stability) and pops it on the handshake.
    initial begin : monitor
        beat_t e;
        bit    bad;
        forever begin
            @(negedge clock);
            if (lhs_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: lhs_valid=1 with no beat queued");
                end else begin
                    e = exp_q[0];
                    bad = 0;
                    if (lhs_start !== e.s) begin bad = 1; $display("FAIL beat_start: got %0b want %0b", lhs_start, e.s); end
                    if (lhs_last  !== e.l) begin bad = 1; $display("FAIL beat_last: got %0b want %0b", lhs_last, e.l); end
                    if (lhs_ptr   !== e.ptr) begin bad = 1; $display("FAIL beat_ptr: got %0h want %0h", lhs_ptr, e.ptr); end
                    if (lhs_col   !== e.col) begin bad = 1; $display("FAIL beat_col: got %0h want %0h", lhs_col, e.col); end
                    if (lhs_data  !== e.data) begin bad = 1; $display("FAIL beat_data: got %0h want %0h", lhs_data, e.data); end
                    if (bad) miscompares++;
                    if (lhs_ready_ns) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Builds the expected beats from the queued entry list, drives the
    // entries, then checks handshake timing and err around the matrix.
    task automatic run_matrix(input int stall, input logic [N*dbLgN-1:0] hand_ptr, input bit use_hand);
        int    cnt[N];
        int    sc[$], sd[$];
        int    lastrow, n, nb, acc;
        bit    exp_err;
        beat_t b;
        lastrow = 0;
        exp_err = 0;
        for (int r = 0; r < N; r++) cnt[r] = 0;
        for (int i = 0; i < mrow.size(); i++) begin
            if (sc.size() == N*N || mrow[i] < lastrow) exp_err = 1;
            else begin
                sc.push_back(mcol[i]);
                sd.push_back(mdata[i]);
                cnt[mrow[i]]++;
                lastrow = mrow[i];
            end
        end
        n  = sc.size();
        nb = (n == 0) ? 1 : (n + N - 1) / N;
        for (int k = 0; k < nb; k++) begin
            b.s = (k == 0);
            b.l = (k == nb - 1);
            acc = 0;
            b.ptr = '0;
            for (int r = 0; r < N; r++) begin
                b.ptr[r*dbLgN +: dbLgN] = dbLgN'(acc);
                acc += cnt[r];
            end
            b.col = '0;
            b.data = '0;
            for (int j = 0; j < N; j++) begin
                if (k*N + j < n) begin
                    b.col[j*lgN +: lgN] = lgN'(sc[k*N + j]);
                    b.data[j*W +: W]    = W'(sd[k*N + j]);
                end
            end
            exp_q.push_back(b);
        end

        lhs_ready_ns = (stall == 0);
        for (int i = 0; i < mrow.size(); i++) begin
            in_valid = 1'b1;
            in_row   = lgN'(mrow[i]);
            in_col   = lgN'(mcol[i]);
            in_data  = W'(mdata[i]);
            in_last  = (i == mrow.size() - 1);
            if (i == 0 || i == mrow.size() - 1) chk("in_ready_collect", 128'(in_ready), 128'(1));
            @(posedge clock); #1;
            if (i == 0) chk("err_clear_first", 128'(err), 128'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("first_beat_valid", 128'(lhs_valid), 128'(1));
        chk("in_ready_emit", 128'(in_ready), 128'(0));
        chk("err_in_emit", 128'(err), 128'(exp_err));
        if (use_hand) chk("hand_ptr", lhs_ptr, 128'(hand_ptr));
        if (stall > 0) begin
            repeat (stall) @(posedge clock);
            #1 lhs_ready_ns = 1'b1;
        end
        repeat (nb) @(posedge clock);
        #1;
        chk("busy_after_last", 128'(busy), 128'(0));
        chk("in_ready_after_last", 128'(in_ready), 128'(1));
        chk("err_sticky_idle", 128'(err), 128'(exp_err));
        chk("beats_left", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        mrow.delete();
        mcol.delete();
        mdata.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 128'(lhs_valid), 128'(0));
        chk({tag, "_start"}, 128'(lhs_start), 128'(0));
        chk({tag, "_last"},  128'(lhs_last),  128'(0));
        chk({tag, "_busy"},  128'(busy),      128'(0));
        chk({tag, "_err"},   128'(err),       128'(0));
        chk({tag, "_ptr"},   lhs_ptr,         128'(0));
        chk({tag, "_col"},   128'(lhs_col),   128'(0));
        chk({tag, "_data"},  lhs_data,        128'(0));
    endtask

    initial begin : stim
        logic [N*dbLgN-1:0] hp;
        reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_row = '0; in_col = '0; in_data = '0;
        lhs_ready_ns = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        // diagonal: one full beat, ptr[r]=r
        for (int i = 0; i < 16; i++) add(i, i, i + 1);
        for (int r = 0; r < N; r++) hp[r*dbLgN +: dbLgN] = dbLgN'(r);
        run_matrix(0, hp, 1);

        // 16 in row 0, 4 in row 1: two beats
        for (int i = 0; i < 16; i++) add(0, i, 8'h10 + i);
        for (int i = 0; i < 4; i++)  add(1, i, 8'h40 + i);
        hp = '0;
        hp[1*dbLgN +: dbLgN] = 8'd16;
        for (int r = 2; r < N; r++) hp[r*dbLgN +: dbLgN] = 8'd20;
        run_matrix(0, hp, 1);

        // single entry in the top row: all pointers zero
        add(15, 3, 7);
        run_matrix(0, '0, 1);

        // 40 entries over rows 0..13, downstream stalls 5 cycles on beat 0
        for (int i = 0; i < 40; i++) add(i / 3, (i * 5) % 16, i * 7 + 1);
        run_matrix(5, '0, 0);

        // row order violation: row-1 entry dropped, err set
        add(2, 5, 9);
        add(1, 1, 1);
        add(3, 4, 8'h22);
        hp = '0;
        hp[3*dbLgN +: dbLgN] = 8'd1;
        for (int r = 4; r < N; r++) hp[r*dbLgN +: dbLgN] = 8'd2;
        run_matrix(0, hp, 1);

        // next matrix clears err on its first entry
        add(0, 6, 8'h55);
        run_matrix(0, '0, 0);

        // overflow: 256 entries fill the buffer, a 257th with last is dropped
        for (int i = 0; i < 256; i++) add(i / 16, i % 16, i);
        add(15, 0, 8'hAA);
        for (int r = 0; r < N; r++) hp[r*dbLgN +: dbLgN] = dbLgN'(16 * r);
        run_matrix(0, hp, 1);

        // reset in the middle of collecting 5 entries
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_last = 1'b0;
            in_row = lgN'(i); in_col = lgN'(i); in_data = W'(i + 3);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_busy", 128'(busy), 128'(1));
        #2 reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        chk("midreset_in_ready", 128'(in_ready), 128'(1));
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        chk("post_reset_in_ready", 128'(in_ready), 128'(1));
        add(4, 2, 8'h33);
        hp = '0;
        for (int r = 5; r < N; r++) hp[r*dbLgN +: dbLgN] = 8'd1;
        run_matrix(0, hp, 1);

        repeat (3) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
